// File: rtl/dm_arbiter_if.sv
// Data-memory arbiter bus: two requester ports plus the DM port.
// The arbiter sits on the slave modport; the requester/memory side on master.
interface dm_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [1:0]  m0_size;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [1:0]  m1_size;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [3:0]  dm_be;
  logic [31:0] dm_rd;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_size,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_size,
    input  dm_rd,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output dm_we, dm_addr, dm_wd, dm_be
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_size,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_size,
    output dm_rd,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  dm_we, dm_addr, dm_wd, dm_be
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin data-memory arbiter, two cycles per access,
// with byte-lane steering and misaligned/out-of-range detection.
module dm_arbiter #(
  parameter int unsigned DM_WORDS = 3072
) (
  input logic         clk,
  input logic         reset,
  dm_arbiter_if.slave bus
);
  localparam logic [32:0] DM_BYTES = {1'b0, DM_WORDS} << 2;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e      state_q, state_d;
  logic        any_req, pick;
  logic        last_q, sel_q;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        gnt0_q, gnt1_q;
  logic        rv0_q, rv1_q;
  logic        err0_q, err1_q;
  logic [31:0] rdata0_q, rdata1_q;
  logic        in_access;
  logic        err_w;
  logic [3:0]  be_w;
  logic [31:0] wd_w;

  // pick = 1 selects m1; m0 wins a conflict unless it was granted last
  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
    pick    = bus.m1_req & (~bus.m0_req | ~last_q);
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (any_req) state_d = ACCESS;
      ACCESS: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    err_w = 1'b0;
    be_w  = 4'b0000;
    wd_w  = wdata_q;
    unique case (1'b1)
      size_q == 2'b00: begin
        be_w  = 4'b1111;
        err_w = |addr_q[1:0];
      end
      size_q == 2'b01: begin
        be_w  = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_w  = {2{wdata_q[15:0]}};
        err_w = addr_q[0];
      end
      size_q == 2'b10: begin
        be_w = 4'b0001 << addr_q[1:0];
        wd_w = {4{wdata_q[7:0]}};
      end
      default: err_w = 1'b1;
    endcase
    if ({1'b0, addr_q} >= DM_BYTES) err_w = 1'b1;
  end

  // reset gates the write strobe so an aborted access never lands in DM
  assign in_access   = state_q == ACCESS;
  assign bus.dm_we   = in_access & we_q & ~err_w & ~reset;
  assign bus.dm_be   = (in_access & ~err_w & ~reset) ? be_w : 4'b0000;
  assign bus.dm_addr = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.dm_wd   = in_access ? wd_w : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q   <= 1'b1;
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      size_q   <= 2'b00;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      if (state_q == IDLE && any_req) begin
        sel_q   <= pick;
        last_q  <= pick;
        we_q    <= pick ? bus.m1_we    : bus.m0_we;
        addr_q  <= pick ? bus.m1_addr  : bus.m0_addr;
        wdata_q <= pick ? bus.m1_wdata : bus.m0_wdata;
        size_q  <= pick ? bus.m1_size  : bus.m0_size;
        gnt0_q  <= ~pick;
        gnt1_q  <= pick;
      end
      if (in_access) begin
        if (sel_q) begin
          rdata1_q <= bus.dm_rd;
          rv1_q    <= 1'b1;
          err1_q   <= err_w;
        end else begin
          rdata0_q <= bus.dm_rd;
          rv0_q    <= 1'b1;
          err0_q   <= err_w;
        end
      end
    end
  end

  assign bus.m0_gnt    = gnt0_q;
  assign bus.m1_gnt    = gnt1_q;
  assign bus.m0_rvalid = rv0_q;
  assign bus.m1_rvalid = rv1_q;
  assign bus.m0_err    = err0_q;
  assign bus.m1_err    = err1_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the two-requester memory.
module tb_dm_arbiter;
  localparam int unsigned DM_WORDS = 3072;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  always #5 clk = ~clk;

  dm_arbiter_if bus();

  dm_arbiter #(.DM_WORDS(DM_WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int fails   = 0;

  logic [31:0] mem     [0:DM_WORDS-1];
  logic [31:0] ref_mem [0:DM_WORDS-1];

  function automatic logic [31:0] init_word(int unsigned i);
    if (i == 4) return 32'hDEADBEEF;
    return (i * 32'h9E3779B9) ^ 32'h13572468;
  endfunction

  function automatic logic [31:0] oor_word(logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hA5A5A5A5;
  endfunction

  // behavioural DM: combinational read, byte-enabled write
  logic [29:0] widx;
  assign widx = bus.dm_addr[31:2];
  always_comb begin
    if (widx < 30'(DM_WORDS)) bus.dm_rd = mem[widx[11:0]];
    else                      bus.dm_rd = oor_word(bus.dm_addr);
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int unsigned i = 0; i < DM_WORDS; i++) mem[i] <= init_word(i);
    end else if (bus.dm_we && widx < 30'(DM_WORDS)) begin
      for (int b = 0; b < 4; b++)
        if (bus.dm_be[b]) mem[widx[11:0]][8*b +: 8] <= bus.dm_wd[8*b +: 8];
    end
  end

  typedef struct {
    logic        g0, g1, r0, r1, e;
    logic [31:0] rd;
    logic        dwe;
    logic [3:0]  be;
    logic [31:0] da, wd;
    logic        wdx;
  } exp_t;

  exp_t slot [4];

  task automatic idle_inputs();
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_size = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_size = 0;
  endtask

  task automatic drive(int r, logic req, logic we, logic [31:0] addr,
                       logic [31:0] wdata, logic [1:0] size);
    if (r == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr;
      bus.m0_wdata = wdata; bus.m0_size = size;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr;
      bus.m1_wdata = wdata; bus.m1_size = size;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; mem_init = 1;
    idle_inputs();
    @(negedge clk);
    reset = 0; mem_init = 0;
  endtask

  task automatic test_reset();
    reset = 1; mem_init = 1;
    idle_inputs();
    drive(0, 1, 1, 32'h10, 32'h55, 2'b00);
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid,
         bus.m0_err, bus.m1_err, bus.dm_we, bus.dm_be} !== 11'b0) begin
      fails++;
      $display("FAIL reset_ctl got gnt=%b%b rv=%b%b err=%b%b we=%b be=%b exp all 0",
               bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid,
               bus.m0_err, bus.m1_err, bus.dm_we, bus.dm_be);
    end
    vectors++;
    if ({bus.m0_rdata, bus.m1_rdata, bus.dm_addr, bus.dm_wd} !== 128'b0) begin
      fails++;
      $display("FAIL reset_data got rd0=%h rd1=%h addr=%h wd=%h exp 0",
               bus.m0_rdata, bus.m1_rdata, bus.dm_addr, bus.dm_wd);
    end
    mem_init = 0;
  endtask

  task automatic test_single_load();
    do_reset();
    drive(0, 1, 0, 32'h10, 32'h0, 2'b00);
    @(negedge clk);
    vectors++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.dm_we, bus.dm_be} !== 8'b10001111
        || bus.dm_addr !== 32'h10) begin
      fails++;
      $display("FAIL load_access got gnt=%b%b rv=%b we=%b be=%b addr=%h exp 10 0 0 1111 00000010",
               bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.dm_we, bus.dm_be, bus.dm_addr);
    end
    idle_inputs();
    @(negedge clk);
    vectors++;
    if ({bus.m0_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.m0_err} !== 4'b0100
        || bus.m0_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL load_resp got gnt=%b rv=%b%b err=%b rdata=%h exp 0 10 0 deadbeef",
               bus.m0_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m0_rdata);
    end
  endtask

  task automatic test_byte_store();
    logic [31:0] w1;
    logic [31:0] expw;
    w1 = init_word(1);
    expw = {8'hAB, w1[23:0]};
    drive(1, 1, 1, 32'h7, 32'h000000AB, 2'b10);
    @(negedge clk);
    vectors++;
    if ({bus.m1_gnt, bus.m0_gnt, bus.dm_we, bus.dm_be} !== 7'b1011000
        || bus.dm_wd !== 32'hABABABAB || bus.dm_addr !== 32'h4) begin
      fails++;
      $display("FAIL byte_store got gnt1=%b gnt0=%b we=%b be=%b wd=%h addr=%h exp 1 0 1 1000 abababab 4",
               bus.m1_gnt, bus.m0_gnt, bus.dm_we, bus.dm_be, bus.dm_wd, bus.dm_addr);
    end
    idle_inputs();
    @(negedge clk);
    vectors++;
    if ({bus.dm_we, bus.m1_rvalid, bus.m0_rvalid, bus.m1_err} !== 4'b0100
        || bus.m1_rdata !== w1) begin
      fails++;
      $display("FAIL byte_store_resp got we=%b rv1=%b rv0=%b err=%b rdata=%h exp 0 1 0 0 %h",
               bus.dm_we, bus.m1_rvalid, bus.m0_rvalid, bus.m1_err, bus.m1_rdata, w1);
    end
    vectors++;
    if (mem[1] !== expw) begin
      fails++;
      $display("FAIL byte_store_mem got %h exp %h", mem[1], expw);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    drive(0, 1, 0, 32'h40, 32'h0, 2'b00);
    drive(1, 1, 0, 32'h80, 32'h0, 2'b00);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.m0_gnt !== logic'(i % 4 == 1) || bus.m1_gnt !== logic'(i % 4 == 3)) begin
        fails++;
        $display("FAIL conflict_c%0d got gnt=%b%b exp %b%b", i, bus.m0_gnt, bus.m1_gnt,
                 i % 4 == 1, i % 4 == 3);
      end
    end
    idle_inputs();
  endtask

  task automatic test_errors();
    logic        t_we   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] t_addr [4] = '{32'h3, 32'h2, 32'h3000, 32'h0};
    logic [1:0]  t_size [4] = '{2'b01, 2'b00, 2'b00, 2'b11};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, t_we[i], t_addr[i], 32'hCAFEF00D, t_size[i]);
      @(negedge clk);
      vectors++;
      if ({bus.m0_gnt, bus.dm_we, bus.dm_be} !== 6'b100000) begin
        fails++;
        $display("FAIL err%0d_access got gnt=%b we=%b be=%b exp 1 0 0000",
                 i, bus.m0_gnt, bus.dm_we, bus.dm_be);
      end
      idle_inputs();
      @(negedge clk);
      vectors++;
      if ({bus.m0_rvalid, bus.m0_err} !== 2'b11) begin
        fails++;
        $display("FAIL err%0d_resp got rv=%b err=%b exp 1 1", i, bus.m0_rvalid, bus.m0_err);
      end
    end
    vectors++;
    if (mem[0] !== init_word(0)) begin
      fails++;
      $display("FAIL err_mem got %h exp %h", mem[0], init_word(0));
    end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    drive(1, 1, 1, 32'h20, 32'h11223344, 2'b00);
    @(negedge clk);
    vectors++;
    if (bus.m1_gnt !== 1'b1) begin
      fails++;
      $display("FAIL abort_gnt got %b exp 1", bus.m1_gnt);
    end
    reset = 1;
    idle_inputs();
    @(negedge clk);
    reset = 0;
    vectors++;
    if (bus.m1_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL abort_rvalid got %b exp 0", bus.m1_rvalid);
    end
    drive(0, 1, 0, 32'h0, 32'h0, 2'b00);
    drive(1, 1, 0, 32'h4, 32'h0, 2'b00);
    @(negedge clk);
    vectors++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.m1_rvalid} !== 3'b100) begin
      fails++;
      $display("FAIL abort_next got gnt=%b%b rv1=%b exp 10 0",
               bus.m0_gnt, bus.m1_gnt, bus.m1_rvalid);
    end
    vectors++;
    if (mem[8] !== init_word(8)) begin
      fails++;
      $display("FAIL abort_mem got %h exp %h", mem[8], init_word(8));
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic        act [2];
    logic        we_r [2];
    logic [31:0] ad_r [2];
    logic [31:0] wd_r [2];
    logic [1:0]  sz_r [2];
    int          free_at = 0;
    int          last = 1;
    bit          mem_ok = 1;
    exp_t        s;
    do_reset();
    for (int unsigned i = 0; i < DM_WORDS; i++) ref_mem[i] = init_word(i);
    for (int i = 0; i < 4; i++) slot[i] = '{default: '0};
    for (int r = 0; r < 2; r++) act[r] = 0;
    for (int k = 0; k < 500; k++) begin
      if (k > 0) @(negedge clk);
      s = slot[k % 4];
      vectors++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid} !== {s.g0, s.g1, s.r0, s.r1}) begin
        fails++;
        $display("FAIL rand_hs c%0d got gnt=%b%b rv=%b%b exp %b%b %b%b", k,
                 bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, s.g0, s.g1, s.r0, s.r1);
      end
      vectors++;
      if ({bus.dm_we, bus.dm_be, bus.dm_addr} !== {s.dwe, s.be, s.da}
          || (!s.wdx && bus.dm_wd !== s.wd)) begin
        fails++;
        $display("FAIL rand_dm c%0d got we=%b be=%b addr=%h wd=%h exp %b %b %h %h", k,
                 bus.dm_we, bus.dm_be, bus.dm_addr, bus.dm_wd, s.dwe, s.be, s.da, s.wd);
      end
      if (s.r0) begin
        vectors++;
        if ({bus.m0_err, bus.m0_rdata} !== {s.e, s.rd}) begin
          fails++;
          $display("FAIL rand_resp0 c%0d got err=%b rd=%h exp %b %h", k,
                   bus.m0_err, bus.m0_rdata, s.e, s.rd);
        end
      end
      if (s.r1) begin
        vectors++;
        if ({bus.m1_err, bus.m1_rdata} !== {s.e, s.rd}) begin
          fails++;
          $display("FAIL rand_resp1 c%0d got err=%b rd=%h exp %b %h", k,
                   bus.m1_err, bus.m1_rdata, s.e, s.rd);
        end
      end
      slot[k % 4] = '{default: '0};
      // requesters: hold until granted, then maybe issue again at once
      for (int r = 0; r < 2; r++) begin
        if ((r == 0 && s.g0) || (r == 1 && s.g1)) act[r] = 0;
        if (!act[r] && $urandom_range(0, 2) == 0) begin
          act[r]  = 1;
          we_r[r] = 1'($urandom_range(0, 1));
          wd_r[r] = $urandom;
          sz_r[r] = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
          case ($urandom_range(0, 15))
            0:       ad_r[r] = 4 * DM_WORDS - 8 + $urandom_range(0, 15);
            1:       ad_r[r] = $urandom;
            default: ad_r[r] = $urandom_range(0, 255);
          endcase
          if ($urandom_range(0, 1) == 1) begin
            if (sz_r[r] == 2'b00) ad_r[r][1:0] = 2'b00;
            if (sz_r[r] == 2'b01) ad_r[r][0] = 1'b0;
          end
        end
        drive(r, act[r], we_r[r], ad_r[r], wd_r[r], sz_r[r]);
      end
      // transaction model
      if (k >= free_at && (act[0] || act[1])) begin
        int          w, n, ofs;
        logic        err;
        logic [3:0]  be;
        logic [31:0] wd, rd, a;
        w   = (act[0] && act[1]) ? (last == 1 ? 0 : 1) : (act[0] ? 0 : 1);
        a   = ad_r[w];
        n   = (sz_r[w] == 2'b00) ? 4 : (sz_r[w] == 2'b01) ? 2 : (sz_r[w] == 2'b10) ? 1 : 0;
        ofs = int'(a % 4);
        err = (n == 0) || (ofs % n != 0) || (longint'(a) >= longint'(4 * DM_WORDS));
        be  = err ? 4'b0000 : 4'(((1 << n) - 1) << ofs);
        wd  = 32'h0;
        if (n != 0)
          for (int l = 0; l < 4; l++) wd[8*l +: 8] = wd_r[w][8*(l % n) +: 8];
        rd = (longint'(a) < longint'(4 * DM_WORDS)) ? ref_mem[a / 4] : oor_word(a);
        slot[(k+1) % 4].g0  = (w == 0);
        slot[(k+1) % 4].g1  = (w == 1);
        slot[(k+1) % 4].dwe = we_r[w] && !err;
        slot[(k+1) % 4].be  = be;
        slot[(k+1) % 4].da  = {a[31:2], 2'b00};
        slot[(k+1) % 4].wd  = wd;
        slot[(k+1) % 4].wdx = (n == 0);
        slot[(k+2) % 4].r0  = (w == 0);
        slot[(k+2) % 4].r1  = (w == 1);
        slot[(k+2) % 4].e   = err;
        slot[(k+2) % 4].rd  = rd;
        if (we_r[w] && !err)
          for (int l = 0; l < 4; l++)
            if (be[l]) ref_mem[a / 4][8*l +: 8] = wd[8*l +: 8];
        last    = w;
        free_at = k + 2;
      end
    end
    idle_inputs();
    repeat (3) @(negedge clk);
    for (int unsigned i = 0; i < DM_WORDS; i++)
      if (mem[i] !== ref_mem[i]) mem_ok = 0;
    vectors++;
    if (!mem_ok) begin
      fails++;
      $display("FAIL rand_mem got memory contents differing from model exp identical");
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_byte_store();
    test_conflict();
    test_errors();
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
